log_stream_serializer: RTL and testbench

Parametrised successor to the fixed 4-byte SPI-log-to-UART path in the top level. It buffers fixed-width log records in a FIFO and serializes each record MSB-byte-first onto the 8-bit UART transmit strobe interface. It arbitrates that interface with a lower-priority pass-through byte channel used by the user command parser. Overflow is counted instead of being silently lost. Sits between spi_flash logging outputs, user_command_parser and uart.

---
 rtl/log_stream_serializer.sv | 151 +++++++++++++++
 tb/tb_log_stream_serializer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/log_stream_serializer.sv
// rtl/log_stream_serializer.sv - log record FIFO serialized MSB-byte-first to uart, user byte pass-through
// Optional: define LOG_HEADER_EN to prefix each record with the HEADER sync byte.
module log_stream_serializer #(
    parameter int         WORD_BYTES = 4,
    parameter int         DEPTH      = 16,
    parameter int         DROP_WIDTH = 16,
    parameter logic [7:0] HEADER     = 8'hA5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    log_strobe,
    input  logic [WORD_BYTES*8-1:0] log_data,
    output logic                    log_full,
    output logic [DROP_WIDTH-1:0]   drop_count,
    input  logic                    inhibit,
    input  logic [7:0]              user_txd,
    input  logic                    user_txd_strobe,
    output logic                    user_txd_ready,
    output logic [7:0]              uart_txd,
    output logic                    uart_txd_strobe,
    input  logic                    uart_txd_ready
);

`ifdef LOG_HEADER_EN
    localparam int SR_BYTES = WORD_BYTES + 1;
`else
    localparam int SR_BYTES = WORD_BYTES;
`endif
    localparam int               SR_W     = SR_BYTES * 8;
    localparam int               PW       = $clog2(DEPTH);
    localparam int               CW       = PW + 1;
    localparam logic [CW-1:0]    DEPTH_C  = CW'(DEPTH);
    localparam logic [3:0]       LOAD_CNT = 4'(SR_BYTES);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t state;
    state_t state_next;

    logic [WORD_BYTES*8-1:0] mem [DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           count;
    logic [CW-1:0]           count_next;
    logic [SR_W-1:0]         sr;
    logic [SR_W-1:0]         sr_load;
    logic [3:0]              byte_cnt;
    logic                    wr_en;
    logic                    pop;
    logic                    send_byte;
    logic                    user_take;
    logic                    fifo_empty;

    assign fifo_empty = (count == '0);
    // Admission uses the current count only; a same-cycle pop never frees a slot.
    assign wr_en      = log_strobe && (count != DEPTH_C);
    assign count_next = count + CW'(wr_en) - CW'(pop);

`ifdef LOG_HEADER_EN
    assign sr_load = {HEADER, mem[rd_ptr]};
`else
    logic unused_header;
    assign unused_header = ^HEADER;
    assign sr_load       = mem[rd_ptr];
`endif

    assign user_txd_ready = !reset && uart_txd_ready && (state == IDLE) && fifo_empty
                            && !inhibit && !uart_txd_strobe;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Records are only popped once the uart can take bytes, so a stalled
    // uart leaves the full DEPTH available for queued records.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        send_byte  = 1'b0;
        user_take  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && uart_txd_ready) begin
                    pop        = 1'b1;
                    state_next = SEND;
                end else if (user_txd_strobe && user_txd_ready) begin
                    user_take = 1'b1;
                end
            end
            SEND: begin
                if (uart_txd_ready && !uart_txd_strobe) begin
                    send_byte = 1'b1;
                    if (byte_cnt == 4'd1) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= log_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            log_full        <= 1'b0;
            drop_count      <= '0;
            sr              <= '0;
            byte_cnt        <= '0;
            uart_txd        <= 8'h00;
            uart_txd_strobe <= 1'b0;
        end else begin
            count    <= count_next;
            log_full <= (count_next == DEPTH_C);
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (log_strobe && !wr_en && (drop_count != '1)) begin
                drop_count <= drop_count + DROP_WIDTH'(1);
            end
            uart_txd_strobe <= send_byte || user_take;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                sr       <= sr_load;
                byte_cnt <= LOAD_CNT;
            end else if (send_byte) begin
                uart_txd <= sr[SR_W-1 -: 8];
                sr       <= sr << 8;
                byte_cnt <= byte_cnt - 4'd1;
            end
            if (user_take) begin
                uart_txd <= user_txd;
            end
        end
    end

endmodule

// File: tb/tb_log_stream_serializer.sv
// tb/tb_log_stream_serializer.sv - directed self-checking bench for log_stream_serializer
module tb_log_stream_serializer;

    localparam int WB = 4;
`ifdef LOG_HEADER_EN
    localparam int HB = 1;
`else
    localparam int HB = 0;
`endif
    localparam int NB = WB + HB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          log_strobe = 1'b0;
    logic [WB*8-1:0] log_data = '0;
    logic          log_full;
    logic [15:0]   drop_count;
    logic          inhibit = 1'b0;
    logic [7:0]    user_txd = 8'h00;
    logic          user_txd_strobe = 1'b0;
    logic          user_txd_ready;
    logic [7:0]    uart_txd;
    logic          uart_txd_strobe;
    logic          uart_txd_ready = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [7:0] mon_b[$];
    int         mon_c[$];

    log_stream_serializer dut (
        .clk             (clk),
        .reset           (reset),
        .log_strobe      (log_strobe),
        .log_data        (log_data),
        .log_full        (log_full),
        .drop_count      (drop_count),
        .inhibit         (inhibit),
        .user_txd        (user_txd),
        .user_txd_strobe (user_txd_strobe),
        .user_txd_ready  (user_txd_ready),
        .uart_txd        (uart_txd),
        .uart_txd_strobe (uart_txd_strobe),
        .uart_txd_ready  (uart_txd_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // cyc at the falling edge is the index of the rising edge that produced the strobe
    always @(negedge clk) begin
        if (uart_txd_strobe) begin
            mon_b.push_back(uart_txd);
            mon_c.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        mon_b.delete();
        mon_c.delete();
    endtask

    task automatic write_rec(input logic [31:0] d, output int t);
        log_data   = d;
        log_strobe = 1'b1;
        t          = cyc + 1;
        tick();
        log_strobe = 1'b0;
    endtask

    task automatic expect_rec(input string tag, input logic [31:0] d, input int t, input bit chk_cyc);
        logic [31:0] dv;
        logic [7:0]  eb;
        dv = d;
        check({tag, "_avail"}, 64'(mon_b.size() >= NB), 64'd1);
        for (int k = 0; k < NB; k++) begin
            if (mon_b.size() == 0) break;
            if (k < HB) eb = 8'hA5;
            else        eb = dv[(WB-1-(k-HB))*8 +: 8];
            check($sformatf("%s_b%0d", tag, k), 64'(mon_b.pop_front()), 64'(eb));
            if (chk_cyc) check($sformatf("%s_t%0d", tag, k), 64'(mon_c.pop_front()), 64'(t + 2 + 2*k));
            else         void'(mon_c.pop_front());
        end
    endtask

    initial begin
        int t;
        int t0;
        int gap;

        // reset state
        uart_txd_ready = 1'b1;
        tick(3);
        check("rst_strobe", 64'(uart_txd_strobe), 64'd0);
        check("rst_txd",    64'(uart_txd),        64'h00);
        check("rst_drop",   64'(drop_count),      64'd0);
        check("rst_full",   64'(log_full),        64'd0);
        check("rst_uready", 64'(user_txd_ready),  64'd0);
        reset = 1'b0;
        tick(2);
        check("idle_uready", 64'(user_txd_ready), 64'd1);
        clear_mon();

        // single record latency and byte order
        write_rec(32'h00001004, t);
        tick(2*NB + 6);
        expect_rec("t1", 32'h00001004, t, 1'b1);
        check("t1_empty",  64'(mon_b.size()),    64'd0);
        check("t1_idle",   64'(user_txd_ready),  64'd1);

        // back-to-back records: second pop in the IDLE cycle after the last byte
        write_rec(32'hDEADBEEF, t);
        write_rec(32'h33445566, t0);
        tick(4*NB + 8);
        expect_rec("b2b0", 32'hDEADBEEF, t, 1'b1);
        expect_rec("b2b1", 32'h33445566, t + 2*NB, 1'b1);
        check("b2b_empty", 64'(mon_b.size()), 64'd0);

        // user pass-through
        check("usr_ready", 64'(user_txd_ready), 64'd1);
        user_txd        = 8'h41;
        user_txd_strobe = 1'b1;
        t = cyc + 1;
        tick();
        user_txd_strobe = 1'b0;
        check("usr_ready_busy", 64'(user_txd_ready), 64'd0);
        tick(3);
        check("usr_n", 64'(mon_b.size()), 64'd1);
        if (mon_b.size() > 0) begin
            check("usr_byte", 64'(mon_b[0]), 64'h41);
            check("usr_t",    64'(mon_c[0]), 64'(t));
        end
        clear_mon();
        inhibit = 1'b1;
        tick();
        check("inh_ready", 64'(user_txd_ready), 64'd0);
        user_txd        = 8'h42;
        user_txd_strobe = 1'b1;
        tick();
        user_txd_strobe = 1'b0;
        tick(3);
        check("inh_nostrobe", 64'(mon_b.size()), 64'd0);
        inhibit = 1'b0;
        tick();

        // overflow with uart stalled
        uart_txd_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            log_data   = {8'(i), 8'(i + 16), 8'(i + 32), 8'(i + 48)};
            log_strobe = 1'b1;
            tick();
            if (i == 14) check("ovf_full15", 64'(log_full), 64'd0);
            if (i == 15) check("ovf_full16", 64'(log_full), 64'd1);
        end
        log_strobe = 1'b0;
        check("ovf_drop", 64'(drop_count), 64'd1);
        check("ovf_nostrobe", 64'(mon_b.size()), 64'd0);
        uart_txd_ready = 1'b1;
        tick(16*2*NB + 10);
        check("ovf_total", 64'(mon_b.size()), 64'(16*NB));
        gap = 1000;
        for (int k = 1; k < mon_c.size(); k++) begin
            if (mon_c[k] - mon_c[k-1] < gap) gap = mon_c[k] - mon_c[k-1];
        end
        check("ovf_min_gap", 64'(gap), 64'd2);
        for (int i = 0; i < 16; i++) begin
            expect_rec($sformatf("ovf_r%0d", i), {8'(i), 8'(i + 16), 8'(i + 32), 8'(i + 48)}, 0, 1'b0);
        end
        check("ovf_drop_held", 64'(drop_count), 64'd1);
        check("ovf_full_clr",  64'(log_full),   64'd0);

        // drop counter saturation
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick();
        check("sat_drop_rst", 64'(drop_count), 64'd0);
        uart_txd_ready = 1'b0;
        log_data       = 32'h0BAD0BAD;
        log_strobe     = 1'b1;
        tick(16 + 65534);
        check("sat_fffe", 64'(drop_count), 64'hFFFE);
        tick(6);
        log_strobe = 1'b0;
        tick();
        check("sat_ffff", 64'(drop_count), 64'hFFFF);
        check("sat_full", 64'(log_full),   64'd1);

        // reset mid-record with records queued
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        uart_txd_ready = 1'b1;
        tick();
        clear_mon();
        write_rec(32'hA1A2A3A4, t);
        write_rec(32'hB1B2B3B4, t0);
        write_rec(32'hC1C2C3C4, t0);
        write_rec(32'hD1D2D3D4, t0);
        tick(1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_two_bytes", 64'(mon_b.size()), 64'd2);
        tick(20);
        check("mid_no_more", 64'(mon_b.size()), 64'd2);
        check("mid_empty",   64'(user_txd_ready), 64'd1);
        check("mid_drop",    64'(drop_count), 64'd0);
        check("mid_full",    64'(log_full),   64'd0);
        clear_mon();
        write_rec(32'h11223344, t);
        tick(2*NB + 6);
        expect_rec("post", 32'h11223344, t, 1'b1);
        check("post_empty", 64'(mon_b.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
